// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (X/Z, Y/Z^2) converter over GF(2^4), poly x^4+x+1.
// Z^-1 = Z^14 is built by a short square-and-multiply sequence on one shared SQR and one MMult.

module gf16_mul (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] p_o
);
  logic [6:0] p;

  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b_i[i]) p = p ^ (7'(a_i) << i);
  end

  // fold x^4..x^6 back using x^4 = x + 1
  assign p_o[0] = p[0] ^ p[4];
  assign p_o[1] = p[1] ^ p[4] ^ p[5];
  assign p_o[2] = p[2] ^ p[5] ^ p[6];
  assign p_o[3] = p[3] ^ p[6];
endmodule

module gf16_sqr (
  input  logic [3:0] a_i,
  output logic [3:0] s_o
);
  // squaring is linear: a0 + a1 x^2 + a2 x^4 + a3 x^6, then reduced
  assign s_o[0] = a_i[0] ^ a_i[2];
  assign s_o[1] = a_i[2];
  assign s_o[2] = a_i[1] ^ a_i[3];
  assign s_o[3] = a_i[3];
endmodule

module proj_to_affine #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X_in,
  input  logic [W-1:0] Y_in,
  input  logic [W-1:0] Z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_aff,
  output logic [W-1:0] y_aff,
  output logic         is_inf
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INF  = 3'd1,
    INV1 = 3'd2,
    INV2 = 3'd3,
    INV3 = 3'd4,
    XA   = 3'd5,
    YA   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0] xr_q, yr_q, zr_q, acc_q, zinv_q;
  logic [W-1:0] x_aff_q, y_aff_q;
  logic         is_inf_q;

  logic [W-1:0] sqr_in, sqr_out;
  logic [W-1:0] mul_a, mul_b, mul_out;

  logic in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  gf16_sqr u_sqr (.a_i(sqr_in), .s_o(sqr_out));
  gf16_mul u_mul (.a_i(mul_a), .b_i(mul_b), .p_o(mul_out));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_fire) state_d = (Z_in != '0) ? INV1 : INF;
      INF:  state_d = DONE;
      INV1: state_d = INV2;
      INV2: state_d = INV3;
      INV3: state_d = XA;
      XA:   state_d = YA;
      YA:   state_d = DONE;
      DONE: if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake flags plus operand steering for the shared SQR / MMult
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sqr_in    = acc_q;
    mul_a     = sqr_out;
    mul_b     = zr_q;
    unique case (state_q)
      INV1: sqr_in = zr_q;
      XA: begin
        mul_a = xr_q;
        mul_b = zinv_q;
      end
      YA: begin
        sqr_in = zinv_q;
        mul_a  = yr_q;
        mul_b  = sqr_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr_q     <= '0;
      yr_q     <= '0;
      zr_q     <= '0;
      acc_q    <= '0;
      zinv_q   <= '0;
      x_aff_q  <= '0;
      y_aff_q  <= '0;
      is_inf_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_fire) begin
          xr_q <= X_in;
          yr_q <= Y_in;
          zr_q <= Z_in;
        end
        INF: begin
          x_aff_q  <= '0;
          y_aff_q  <= '0;
          is_inf_q <= 1'b1;
        end
        INV1: acc_q   <= mul_out;
        INV2: acc_q   <= mul_out;
        INV3: zinv_q  <= sqr_out;
        XA:   x_aff_q <= mul_out;
        YA: begin
          y_aff_q  <= mul_out;
          is_inf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign x_aff  = x_aff_q;
  assign y_aff  = y_aff_q;
  assign is_inf = is_inf_q;

endmodule
